// File: rtl/doorbell_scheduler_if.sv
// Doorbell engine handshake: doorbell request/value/queue out, completion pulses back.
interface doorbell_scheduler_if;
  logic        write_sqtdbl;
  logic [63:0] sqt_addr;
  logic        write_cqhdbl;
  logic [63:0] cqh_addr;
  logic [2:0]  db_qid;
  logic        write_sqtdbl_done;
  logic        write_cqhdbl_done;

  modport master (
    output write_sqtdbl, sqt_addr, write_cqhdbl, cqh_addr, db_qid,
    input  write_sqtdbl_done, write_cqhdbl_done
  );

  modport slave (
    input  write_sqtdbl, sqt_addr, write_cqhdbl, cqh_addr, db_qid,
    output write_sqtdbl_done, write_cqhdbl_done
  );
endinterface

// File: rtl/doorbell_scheduler.sv
// Coalesces per-queue SQ tail / CQ head updates into pending slots and issues
// one doorbell at a time to the doorbell engine, round robin across slots.
module db_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         upd,
  input  logic [W-1:0] upd_val,
  input  logic         clr,
  output logic         pending,
  output logic [W-1:0] val
);
  // A strobe in the grant cycle beats the clear: the slot stays pending with the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      val     <= '0;
    end else if (upd) begin
      pending <= 1'b1;
      val     <= upd_val;
    end else if (clr) begin
      pending <= 1'b0;
    end
  end
endmodule

module doorbell_scheduler #(
  parameter int NUM_Q       = 4,
  parameter int IDX_WIDTH   = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                       user_clk,
  input  logic                       user_reset,
  input  logic                       user_lnk_up,
  input  logic [NUM_Q-1:0]           sq_tail_upd,
  input  logic [NUM_Q*IDX_WIDTH-1:0] sq_tail_val,
  input  logic [NUM_Q-1:0]           cq_head_upd,
  input  logic [NUM_Q*IDX_WIDTH-1:0] cq_head_val,
  input  logic [3:0]                 s_axis_rq_tready,
  doorbell_scheduler_if.master       db,
  output logic [2*NUM_Q-1:0]         db_pending,
  output logic                       db_busy,
  output logic                       db_timeout,
  output logic [1:0]                 sched_state
);
  localparam int NSLOT  = 2 * NUM_Q;
  localparam int SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                 is_sq;
    logic [2:0]           qid;
    logic [IDX_WIDTH-1:0] val;
  } grant_t;

  logic rst, ready;
  assign rst   = user_reset | ~user_lnk_up;
  assign ready = |s_axis_rq_tready;

  // Slot k < NUM_Q is CQ k, slot NUM_Q+q is SQ q.
  logic [NSLOT-1:0]                upd_all, pending, clr;
  logic [NSLOT-1:0][IDX_WIDTH-1:0] upd_val, slot_val;
  assign upd_all = {sq_tail_upd, cq_head_upd};
  assign upd_val = {sq_tail_val, cq_head_val};

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    db_slot #(.W(IDX_WIDTH)) u_slot (
      .clk     (user_clk),
      .rst     (rst),
      .upd     (upd_all[k]),
      .upd_val (upd_val[k]),
      .clr     (clr[k]),
      .pending (pending[k]),
      .val     (slot_val[k])
    );
  end

  state_t            state, state_nxt;
  grant_t            cur;
  logic [SLOT_W-1:0] rr_ptr, gnt_idx, idx;
  logic              gnt_vld, gnt_take, to_hit, to_q, done_match;
  logic [CNT_W-1:0]  wait_cnt;
  logic [2:0]        gnt_qid;

  // Walk downward so the smallest offset from rr_ptr is the one left standing.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      idx = SLOT_W'((int'(rr_ptr) + i) % NSLOT);
      if (pending[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign gnt_qid = (gnt_idx >= SLOT_W'(NUM_Q)) ? 3'(gnt_idx - SLOT_W'(NUM_Q)) : 3'(gnt_idx);
  assign clr     = gnt_take ? (NSLOT'(1) << gnt_idx) : '0;

  assign done_match = cur.is_sq ? db.write_sqtdbl_done : db.write_cqhdbl_done;

  always_comb begin
    state_nxt = state;
    gnt_take  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          gnt_take  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (ready) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done_match) begin
          state_nxt = ST_GAP;
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          to_hit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      cur      <= '0;
      wait_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_take) begin
        cur    <= '{is_sq: (gnt_idx >= SLOT_W'(NUM_Q)), qid: gnt_qid, val: slot_val[gnt_idx]};
        rr_ptr <= (gnt_idx == SLOT_W'(NSLOT - 1)) ? '0 : gnt_idx + SLOT_W'(1);
      end
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + CNT_W'(1) : '0;
      if (to_hit) to_q <= 1'b1;
    end
  end

  // Every output is forced low while reset or link-down is asserted.
  logic live, hold;
  assign live = ~rst;
  assign hold = live & ((state == ST_ISSUE) | (state == ST_WAIT));

  assign db.write_sqtdbl = live & (state == ST_ISSUE) & ready & cur.is_sq;
  assign db.write_cqhdbl = live & (state == ST_ISSUE) & ready & ~cur.is_sq;
  assign db.sqt_addr     = (hold & cur.is_sq)  ? 64'(cur.val) : '0;
  assign db.cqh_addr     = (hold & ~cur.is_sq) ? 64'(cur.val) : '0;
  assign db.db_qid       = hold ? cur.qid : 3'd0;

  assign db_pending  = live ? pending : '0;
  assign db_busy     = live & (state != ST_IDLE);
  assign db_timeout  = live & to_q;
  assign sched_state = live ? state : 2'd0;
endmodule

// File: tb/tb_doorbell_scheduler.sv
// Directed bench: a cycle-vector table for the basic flows plus hand sequences
// for coalescing, round robin, timeout and link-down.
module tb_doorbell_scheduler;
  localparam int NQ = 4;
  localparam int W  = 16;

  logic              user_clk = 1'b0;
  logic              user_reset, user_lnk_up;
  logic [NQ-1:0]     sq_tail_upd, cq_head_upd;
  logic [NQ*W-1:0]   sq_tail_val, cq_head_val;
  logic [3:0]        s_axis_rq_tready;
  logic [2*NQ-1:0]   db_pending;
  logic              db_busy, db_timeout;
  logic [1:0]        sched_state;

  doorbell_scheduler_if dbif();

  doorbell_scheduler #(.NUM_Q(NQ), .IDX_WIDTH(W), .TIMEOUT_CYC(4096)) dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .user_lnk_up      (user_lnk_up),
    .sq_tail_upd      (sq_tail_upd),
    .sq_tail_val      (sq_tail_val),
    .cq_head_upd      (cq_head_upd),
    .cq_head_val      (cq_head_val),
    .s_axis_rq_tready (s_axis_rq_tready),
    .db               (dbif),
    .db_pending       (db_pending),
    .db_busy          (db_busy),
    .db_timeout       (db_timeout),
    .sched_state      (sched_state)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [3:0]  squ, cqu;
    logic [63:0] sqv, cqv;
    logic [3:0]  rdy;
    logic        sqd, cqd;
    logic        ews, ewc;
    logic [63:0] esa, eca;
    logic [2:0]  eq;
    logic [1:0]  est;
    logic [7:0]  ep;
  } vec_t;

  localparam int NROW = 24;
  vec_t tbl [NROW];

  int n_pass = 0, n_tot = 0, viol = 0;
  logic st_rst = 1'b1, st_lnk = 1'b1, st_sq_done = 1'b0, st_cq_done = 1'b0;
  logic [3:0]  st_sq_upd = '0, st_cq_upd = '0, st_rdy = 4'hF;
  logic [63:0] st_sq_val = '0, st_cq_val = '0;
  logic auto_done = 1'b0, sq_due = 1'b0, cq_due = 1'b0;
  int          g_slot[$];
  logic [63:0] g_val[$];

  function automatic vec_t mk(logic [3:0] squ, logic [3:0] cqu, logic [63:0] sqv, logic [63:0] cqv,
                              logic [3:0] rdy, logic sqd, logic cqd, logic ews, logic ewc,
                              logic [63:0] esa, logic [63:0] eca, logic [2:0] eq, logic [1:0] est,
                              logic [7:0] ep);
    vec_t v;
    v.squ = squ; v.cqu = cqu; v.sqv = sqv; v.cqv = cqv; v.rdy = rdy; v.sqd = sqd; v.cqd = cqd;
    v.ews = ews; v.ewc = ewc; v.esa = esa; v.eca = eca; v.eq = eq; v.est = est; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // One clock: apply staged inputs at the falling edge, sample 1ns later.
  task automatic step();
    @(negedge user_clk);
    user_reset       = st_rst;
    user_lnk_up      = st_lnk;
    sq_tail_upd      = st_sq_upd;
    cq_head_upd      = st_cq_upd;
    sq_tail_val      = st_sq_val;
    cq_head_val      = st_cq_val;
    s_axis_rq_tready = st_rdy;
    dbif.write_sqtdbl_done = auto_done ? sq_due : st_sq_done;
    dbif.write_cqhdbl_done = auto_done ? cq_due : st_cq_done;
    #1;
    if (dbif.write_sqtdbl) begin g_slot.push_back(NQ + int'(dbif.db_qid)); g_val.push_back(dbif.sqt_addr); end
    if (dbif.write_cqhdbl) begin g_slot.push_back(int'(dbif.db_qid));      g_val.push_back(dbif.cqh_addr); end
    if ((dbif.write_sqtdbl && dbif.write_cqhdbl) ||
        ((dbif.write_sqtdbl || dbif.write_cqhdbl) && sched_state != 2'd1)) viol++;
    sq_due = dbif.write_sqtdbl;
    cq_due = dbif.write_cqhdbl;
    st_sq_upd = '0; st_cq_upd = '0; st_sq_done = 1'b0; st_cq_done = 1'b0;
  endtask

  task automatic do_reset();
    st_rst = 1'b1; step(); step(); st_rst = 1'b0;
  endtask

  initial begin
    int ncq, nst, wcnt, es;
    logic [63:0] cqv, sqv, ev;

    user_reset = 1'b1; user_lnk_up = 1'b1; s_axis_rq_tready = 4'hF;
    sq_tail_upd = '0; cq_head_upd = '0; sq_tail_val = '0; cq_head_val = '0;
    dbif.write_sqtdbl_done = 1'b0; dbif.write_cqhdbl_done = 1'b0;

    // Table: SQ1 basic doorbell, then a CQ2 doorbell stalled 10 cycles on ready.
    tbl[0] = mk(4'b0010, 4'b0, 64'h5_0000, 64'h0, 4'hF, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd0, 8'h00);
    tbl[1] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd0, 8'h20);
    tbl[2] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 0, 1, 0, 64'h5, 64'h0, 3'd1, 2'd1, 8'h00);
    tbl[3] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 1, 0, 0, 64'h5, 64'h0, 3'd1, 2'd2, 8'h00);
    tbl[4] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 1, 0, 0, 0, 64'h5, 64'h0, 3'd1, 2'd2, 8'h00);
    tbl[5] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd3, 8'h00);
    tbl[6] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd0, 8'h00);
    tbl[7] = mk(4'b0, 4'b0100, 64'h0, 64'h22_0000_0000, 4'h0, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd0, 8'h00);
    tbl[8] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'h0, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd0, 8'h04);
    for (int r = 9; r <= 18; r++)
      tbl[r] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'h0, 0, 0, 0, 0, 64'h0, 64'h22, 3'd2, 2'd1, 8'h00);
    tbl[19] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'h1, 0, 0, 0, 1, 64'h0, 64'h22, 3'd2, 2'd1, 8'h00);
    tbl[20] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'h1, 1, 0, 0, 0, 64'h0, 64'h22, 3'd2, 2'd2, 8'h00);
    tbl[21] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 1, 0, 0, 64'h0, 64'h22, 3'd2, 2'd2, 8'h00);
    tbl[22] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd3, 8'h00);
    tbl[23] = mk(4'b0, 4'b0, 64'h0, 64'h0, 4'hF, 0, 0, 0, 0, 64'h0, 64'h0, 3'd0, 2'd0, 8'h00);

    // Reset: strobes and dones during reset must leave nothing behind.
    step();
    st_sq_upd = 4'b1000; st_sq_val = 64'hABCD_0000_0000_0000; st_sq_done = 1'b1;
    step();
    chk("reset_outs", {dbif.write_sqtdbl, dbif.write_cqhdbl, dbif.sqt_addr, dbif.cqh_addr, dbif.db_qid,
                       db_pending, db_busy, db_timeout, sched_state}, '0);
    st_rst = 1'b0;

    for (int r = 0; r < NROW; r++) begin
      st_sq_upd = tbl[r].squ; st_cq_upd = tbl[r].cqu; st_sq_val = tbl[r].sqv; st_cq_val = tbl[r].cqv;
      st_rdy = tbl[r].rdy; st_sq_done = tbl[r].sqd; st_cq_done = tbl[r].cqd;
      step();
      chk($sformatf("vec%0d", r),
          {dbif.write_sqtdbl, dbif.write_cqhdbl, dbif.sqt_addr, dbif.cqh_addr, dbif.db_qid, sched_state, db_pending, db_busy},
          {tbl[r].ews, tbl[r].ewc, tbl[r].esa, tbl[r].eca, tbl[r].eq, tbl[r].est, tbl[r].ep, (tbl[r].est != 2'd0)});
    end
    st_rdy = 4'hF;

    // Coalescing: CQ0 updated 3, 7, 9 while an SQ0 doorbell is in flight.
    g_slot.delete(); g_val.delete(); auto_done = 1'b1;
    st_sq_upd = 4'b0001; st_sq_val = 64'h11; step();
    step();
    st_cq_upd = 4'b0001; st_cq_val = 64'h3; step();
    st_cq_upd = 4'b0001; st_cq_val = 64'h7; step();
    st_cq_upd = 4'b0001; st_cq_val = 64'h9; step();
    for (int i = 0; i < 40; i++) step();
    ncq = 0; cqv = '0; sqv = '0;
    foreach (g_slot[i]) if (g_slot[i] < NQ) begin ncq++; cqv = g_val[i]; end else sqv = g_val[i];
    chk("coalesce_cnt", ncq, 1);
    chk("coalesce_val", cqv, 64'h9);
    chk("coalesce_sq0", sqv, 64'h11);

    // Round robin from rr_ptr=0 with every slot pending, then a full refill.
    do_reset();
    g_slot.delete(); g_val.delete();
    st_sq_upd = 4'hF; st_cq_upd = 4'hF;
    st_sq_val = {16'h203, 16'h202, 16'h201, 16'h200}; st_cq_val = {16'h103, 16'h102, 16'h101, 16'h100};
    step();
    for (int i = 0; i < 200 && g_slot.size() < 8; i++) step();
    st_sq_upd = 4'hF; st_cq_upd = 4'hF;
    for (int i = 0; i < 200 && g_slot.size() < 16; i++) step();
    for (int k = 0; k < 9; k++) begin
      es = k % 8;
      ev = (es < NQ) ? 64'(32'h100 + es) : 64'(32'h200 + es - NQ);
      if (g_slot.size() > k) chk($sformatf("rr_grant%0d", k), {32'(g_slot[k]), g_val[k]}, {32'(es), ev});
      else chk($sformatf("rr_grant%0d_missing", k), 32'(g_slot.size()), 32'(k + 1));
    end
    for (int i = 0; i < 10; i++) step();

    // Timeout: CQ1 never completes; SQ2 must still be serviced afterwards.
    do_reset();
    auto_done = 1'b0; g_slot.delete(); g_val.delete();
    st_cq_upd = 4'b0010; st_cq_val = 64'h44_0000;
    st_sq_upd = 4'b0100; st_sq_val = 64'h33_0000_0000;
    step();
    wcnt = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (sched_state == 2'd2) wcnt++;
      if (db_timeout) break;
    end
    chk("timeout_flag", db_timeout, 1'b1);
    chk("timeout_wait_cycles", wcnt, 4096);
    chk("timeout_state_idle", sched_state, 2'd0);
    chk("timeout_no_repend", db_pending, 8'h40);
    auto_done = 1'b1; g_slot.delete(); g_val.delete();
    for (int i = 0; i < 20; i++) step();
    nst = 0; sqv = '0;
    foreach (g_slot[i]) if (g_slot[i] == NQ + 2) begin nst++; sqv = g_val[i]; end
    chk("after_timeout_sq2", {32'(nst), sqv}, {32'd1, 64'h33});
    chk("timeout_sticky", db_timeout, 1'b1);

    // Link drop during WAIT abandons the doorbell and clears everything.
    auto_done = 1'b0;
    st_sq_upd = 4'b0001; st_sq_val = 64'h55; step();
    for (int i = 0; i < 20 && sched_state != 2'd2; i++) step();
    chk("lnk_reach_wait", sched_state, 2'd2);
    st_lnk = 1'b0; st_cq_upd = 4'b0010; st_cq_val = 64'h77_0000; st_sq_done = 1'b1;
    step();
    chk("lnk_down_outs", {dbif.write_sqtdbl, dbif.write_cqhdbl, dbif.sqt_addr, dbif.cqh_addr, dbif.db_qid,
                          db_pending, db_busy, db_timeout, sched_state}, '0);
    st_lnk = 1'b1;
    step();
    chk("lnk_up_cleared", {db_pending, db_busy, db_timeout, sched_state, dbif.sqt_addr}, '0);

    chk("strobe_rules", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
